signed_div_seq: RTL and testbench

Sequential signed 32-by-32 divider, the inverse of the combinational Booth multiplier. It produces a 32-bit quotient and a 32-bit remainder using radix-2 restoring division on operand magnitudes, one iteration per clock, followed by one sign-fixup cycle. It sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake. Division truncates toward zero; the remainder takes the sign of the dividend.

---
 rtl/signed_div_seq_if.sv | 33 +++
 rtl/signed_div_seq.sv | 139 +++++++++++++
 tb/tb_signed_div_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/signed_div_seq_if.sv
// Handshake/data bundle for the sequential signed divider.
//   start        request, sampled only while busy is low
//   a, b         signed dividend / divisor, captured on acceptance
//   busy         operation in progress
//   done         one-cycle result strobe
//   quotient     signed quotient (truncated toward zero)
//   remainder    signed remainder (sign of the dividend)
//   div_by_zero  divisor was zero
//   overflow     most-negative dividend divided by -1
`timescale 1ns/1ps
interface signed_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/signed_div_seq.sv
// Sequential signed WIDTH-by-WIDTH divider: radix-2 restoring division on
// operand magnitudes, one quotient bit per clock, then one sign-fixup cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation in flight
//   bus    slave side of signed_div_seq_if (start/a/b in; busy/done/results out)
`timescale 1ns/1ps
module signed_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  signed_div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dq;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic [WIDTH:0]   rem;     // partial remainder
  logic             neg_q;
  logic             neg_r;
  logic             sp_dbz;
  logic             sp_ovf;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_iter;
  logic             is_dbz;
  logic             is_ovf;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] trial;

  // Magnitudes are treated as unsigned, so |MIN_VAL| = MIN_VAL is exact.
  always_comb begin
    abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    is_dbz    = (bus.b == '0);
    is_ovf    = (bus.a == MIN_VAL) && (bus.b == '1);
    // Two guard bits: trial[WIDTH+1] is the borrow of the trial subtraction.
    sh        = {rem, dq[WIDTH-1]};
    trial     = sh - {2'b00, dvs};
    last_iter = (cnt == CW'(WIDTH-1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = (is_dbz || is_ovf) ? FIX : CALC;
      CALC: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    bus.busy = (state != IDLE);
    accept   = (state == IDLE) && bus.start;
  end

  // Iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq     <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      sp_dbz <= 1'b0;
      sp_ovf <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      dq     <= abs_a;
      dvs    <= abs_b;
      rem    <= '0;
      neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      neg_r  <= bus.a[WIDTH-1];
      sp_dbz <= is_dbz;
      sp_ovf <= is_ovf;
      cnt    <= '0;
    end else if (state == CALC) begin
      rem <= trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0];
      dq  <= {dq[WIDTH-2:0], ~trial[WIDTH+1]};
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers change only in FIX. On divide-by-zero the operand is
  // rebuilt from its latched magnitude and sign instead of storing a copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= (state == FIX);
      if (state == FIX) begin
        if (sp_dbz) begin
          bus.quotient    <= '1;
          bus.remainder   <= neg_r ? -dq : dq;
          bus.div_by_zero <= 1'b1;
          bus.overflow    <= 1'b0;
        end else if (sp_ovf) begin
          bus.quotient    <= MIN_VAL;
          bus.remainder   <= '0;
          bus.div_by_zero <= 1'b0;
          bus.overflow    <= 1'b1;
        end else begin
          bus.quotient    <= neg_q ? -dq : dq;
          bus.remainder   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          bus.div_by_zero <= 1'b0;
          bus.overflow    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Directed, table-driven bench for signed_div_seq, plus hand-written
// sequences for ignored start, back-to-back start and mid-operation reset.
`timescale 1ns/1ps
module tb_signed_div_seq;

  logic clk;
  logic rst_n;

  signed_div_seq_if #(.WIDTH(32)) bus_if ();

  signed_div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One operation; optionally pulses a second start with other operands
  // while the first is still busy (inject_at = edge index after acceptance).
  task automatic apply(input vec_t v, input int inject_at, input string tag);
    int cycles;
    int busy_cnt;
    bit got;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = v.a;
    bus_if.b     = v.b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && cycles < 100) begin
      if (bus_if.busy) busy_cnt++;
      if (inject_at > 0 && cycles == inject_at - 1) begin
        bus_if.start = 1'b1;
        bus_if.a     = 32'd50;
        bus_if.b     = 32'd5;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (bus_if.done) got = 1'b1;
    end
    bus_if.start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, cycles, v.lat);
    chk({tag, "_busy_cycles"}, busy_cnt, v.lat);
    chk({tag, "_busy_at_done"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_quotient"}, bus_if.quotient, v.q);
    chk({tag, "_remainder"}, bus_if.remainder, v.r);
    chk({tag, "_div_by_zero"}, 32'(bus_if.div_by_zero), 32'(v.dbz));
    chk({tag, "_overflow"}, 32'(bus_if.overflow), 32'(v.ovf));
    @(posedge clk); #1;
    chk({tag, "_done_single"}, 32'(bus_if.done), 32'd0);
    chk({tag, "_quotient_held"}, bus_if.quotient, v.q);
    chk({tag, "_dbz_held"}, 32'(bus_if.div_by_zero), 32'(v.dbz));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn;
    int cycles;
    int d1;
    int d2;
    logic [31:0] q1, r1, q2, r2;

    //            a             b             q             r             dbz   ovf   lat
    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 33};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 33};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 1};
    vecs[5]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1};
    vecs[6]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 1'b0, 33};
    vecs[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 1'b0, 33};
    vecs[8]  = '{32'd0,        32'd3,        32'd0,        32'd0,        1'b0, 1'b0, 33};
    vecs[9]  = '{32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 1};
    vecs[10] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 1'b0, 33};
    vecs[11] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 33};
    vecs[12] = '{32'd1000000007, 32'd1000,   32'd1000000,  32'd7,        1'b0, 1'b0, 33};

    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_quotient", bus_if.quotient, 32'd0);
    chk("rst_remainder", bus_if.remainder, 32'd0);
    chk("rst_div_by_zero", 32'(bus_if.div_by_zero), 32'd0);
    chk("rst_overflow", 32'(bus_if.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(vecs[i], 0, $sformatf("v%0d", i));

    // Second start at E10 is ignored and leaves no trailing operation.
    apply(vecs[0], 10, "ignore");
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_if.done) dn++;
    end
    chk("ignore_no_extra_done", dn, 0);
    chk("ignore_idle", 32'(bus_if.busy), 32'd0);

    // start held high: operands changed after E0 only affect the second op.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 32'd100;
    bus_if.b     = 32'd7;
    @(posedge clk); #1;
    bus_if.a = 32'd9;
    bus_if.b = 32'd3;
    cycles = 0; d1 = -1; d2 = -1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    while (d2 < 0 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (bus_if.done) begin
        if (d1 < 0) begin
          d1 = cycles; q1 = bus_if.quotient; r1 = bus_if.remainder;
        end else begin
          d2 = cycles; q2 = bus_if.quotient; r2 = bus_if.remainder;
        end
      end
    end
    bus_if.start = 1'b0;
    chk("b2b_first_latency", d1, 33);
    chk("b2b_first_quotient", q1, 32'd14);
    chk("b2b_first_remainder", r1, 32'd2);
    chk("b2b_second_latency", d2, 67);
    chk("b2b_second_quotient", q2, 32'd3);
    chk("b2b_second_remainder", r2, 32'd0);
    repeat (3) @(posedge clk);

    // Reset at E15 of a 100/7 operation.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 32'd100;
    bus_if.b     = 32'd7;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(bus_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_done", 32'(bus_if.done), 32'd0);
    chk("abort_quotient", bus_if.quotient, 32'd0);
    chk("abort_remainder", bus_if.remainder, 32'd0);
    chk("abort_div_by_zero", 32'(bus_if.div_by_zero), 32'd0);
    chk("abort_overflow", 32'(bus_if.overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_if.done || bus_if.busy) dn++;
    end
    chk("abort_no_done", dn, 0);
    apply('{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33}, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
